vga_display_ctrl: RTL

//  Parametrised VGA display controller: pixel-tick divider, H/V timing counters,

---
 rtl/vga_pkg.sv | 68 ++++++
 rtl/vga_timing.sv | 109 ++++++++++
 rtl/vga_display_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display controller.
//   - default 640x480@60 timing (25 MHz pixel clock from 50 MHz)
//   - 3-bit colour codes, where the code is the {R,G,B} value itself
//   - sync/visible flag bundle that travels down the alignment pipeline
//   - helpers: line/frame totals and the colour-request priority encoder
package vga_pkg;

  localparam int DEF_CLK_DIV      = 2;
  localparam int DEF_H_DISPLAY    = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_DISPLAY    = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_GLYPH_LAT    = 1;
  localparam int DEF_BLINK_FRAMES = 30;

  // Coordinate counters are 10 bits wide, so a line or frame may not exceed 1024.
  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1024;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
  } sync_flags_t;

  // Flag value outside any frame: not visible, both syncs inactive (high).
  localparam sync_flags_t FLAGS_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  function automatic int h_total(input int disp, input int fp, input int sw, input int bp);
    return disp + fp + sw + bp;
  endfunction

  function automatic int v_total(input int disp, input int fp, input int sw, input int bp);
    return disp + fp + sw + bp;
  endfunction

  // Lowest set bit of the one-hot request wins when several buttons are pressed.
  function automatic logic [2:0] first_colour(input logic [7:0] sel);
    logic [2:0] code;
    code = WHITE;
    casez (sel)
      8'b???????1: code = BLACK;
      8'b??????10: code = BLUE;
      8'b?????100: code = GREEN;
      8'b????1000: code = CYAN;
      8'b???10000: code = RED;
      8'b??100000: code = MAGENTA;
      8'b?1000000: code = YELLOW;
      8'b10000000: code = WHITE;
      default:     code = WHITE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, horizontal/vertical position counters and the
// stage-0 visible/sync flags derived combinationally from the counters.
// Ports:
//   i_clk, i_reset     system clock, synchronous active-high reset
//   o_p_tick           one-clk pulse per pixel (clk where divider is at CLK_DIV-1)
//   o_pixel_x/y        registered column/line of the pixel being presented
//   o_frame_start      o_p_tick qualified with position (0,0)
//   o_vis_p0           position inside the visible area
//   o_hs_n_p0/vs_n_p0  active-low sync flags for the current position
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_p_tick,
  output logic [CNT_W-1:0] o_pixel_x,
  output logic [CNT_W-1:0] o_pixel_y,
  output logic             o_frame_start,
  output logic             o_vis_p0,
  output logic             o_hs_n_p0,
  output logic             o_vs_n_p0
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // One extra bit so boundaries equal to 1024 still compare correctly.
  localparam logic [CNT_W:0] H_VIS_END = (CNT_W+1)'(H_DISPLAY);
  localparam logic [CNT_W:0] H_SYN_BEG = (CNT_W+1)'(H_DISPLAY + H_FP);
  localparam logic [CNT_W:0] H_SYN_END = (CNT_W+1)'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_VIS_END = (CNT_W+1)'(V_DISPLAY);
  localparam logic [CNT_W:0] V_SYN_BEG = (CNT_W+1)'(V_DISPLAY + V_FP);
  localparam logic [CNT_W:0] V_SYN_END = (CNT_W+1)'(V_DISPLAY + V_FP + V_SYNC);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing: H_TOTAL or V_TOTAL exceeds the 10-bit counter range");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;

  always_comb begin
    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  end

  // The tick is registered from the next divider value, so it is high exactly
  // while the divider sits at CLK_DIV-1 and is low throughout reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_tick <= (w_div_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_tick) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  // Stage 0: flags for the position currently on o_pixel_x/o_pixel_y.
  always_comb begin
    w_h_ext       = {1'b0, r_h};
    w_v_ext       = {1'b0, r_v};
    o_vis_p0      = (w_h_ext < H_VIS_END) && (w_v_ext < V_VIS_END);
    o_hs_n_p0     = !((w_h_ext >= H_SYN_BEG) && (w_h_ext < H_SYN_END));
    o_vs_n_p0     = !((w_v_ext >= V_SYN_BEG) && (w_v_ext < V_SYN_END));
    o_frame_start = r_tick && (r_h == '0) && (r_v == '0);
  end

  assign o_p_tick  = r_tick;
  assign o_pixel_x = r_h;
  assign o_pixel_y = r_v;

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display controller top level.
// Generates pixel coordinates for an external glyph generator, receives one
// glyph bit per pixel GLYPH_LAT p_ticks later, and produces sync/colour
// outputs aligned with that glyph bit.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   color_sel[7:0]      one-hot colour request, bit i selects colour code i
//   blink_en            1 = text blinks every BLINK_FRAMES frames
//   glyph_bit           glyph pixel from the generator
//   p_tick              one-clk pulse per pixel
//   pixel_x/pixel_y     coordinates presented to the glyph generator
//   frame_start         p_tick at position (0,0)
//   hsync/vsync         active-low syncs, aligned with text_rgb
//   video_on, text_on   visible-area and lit-text flags, aligned with text_rgb
//   text_rgb[2:0]       {R,G,B}
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_DISPLAY    = DEF_H_DISPLAY,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_DISPLAY    = DEF_V_DISPLAY,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int GLYPH_LAT    = DEF_GLYPH_LAT,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] color_sel,
  input  logic       blink_en,
  input  logic       glyph_bit,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       text_on,
  output logic [2:0] text_rgb
);

  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

  if (GLYPH_LAT < 0 || GLYPH_LAT > 4) begin : g_bad_lat
    $error("vga_display_ctrl: GLYPH_LAT must be in 0..4");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("vga_display_ctrl: BLINK_FRAMES must be at least 1");
  end

  logic        w_p_tick;
  logic        w_frame_start;
  logic [9:0]  w_pixel_x;
  logic [9:0]  w_pixel_y;
  logic        w_vis_p0;
  logic        w_hs_n_p0;
  logic        w_vs_n_p0;
  sync_flags_t w_flags_p0;
  sync_flags_t w_flags_p1;
  logic        w_text_on_p1;

  logic [2:0]      r_pending;
  logic [2:0]      r_active;
  logic [BC_W-1:0] r_bcnt;
  logic            r_blink_vis;

  logic       r_hsync_p2;
  logic       r_vsync_p2;
  logic       r_video_on_p2;
  logic       r_text_on_p2;
  logic [2:0] r_text_rgb_p2;

  vga_timing #(
    .CLK_DIV   (CLK_DIV),
    .H_DISPLAY (H_DISPLAY),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_DISPLAY (V_DISPLAY),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_p_tick      (w_p_tick),
    .o_pixel_x     (w_pixel_x),
    .o_pixel_y     (w_pixel_y),
    .o_frame_start (w_frame_start),
    .o_vis_p0      (w_vis_p0),
    .o_hs_n_p0     (w_hs_n_p0),
    .o_vs_n_p0     (w_vs_n_p0)
  );

  // Requests are captured on any clk; the displayed colour only changes at
  // the frame boundary so a frame is never drawn in two colours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= WHITE;
      r_active  <= WHITE;
    end else begin
      if (w_frame_start) begin
        r_active <= r_pending;
      end
      if (color_sel != 8'h00) begin
        r_pending <= first_colour(color_sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      r_bcnt      <= '0;
      r_blink_vis <= 1'b1;
    end else if (w_frame_start) begin
      if (r_bcnt == BC_LAST) begin
        r_bcnt      <= '0;
        r_blink_vis <= !r_blink_vis;
      end else begin
        r_bcnt <= r_bcnt + BC_W'(1);
      end
    end
  end

  // Stage 0 -> stage 1: delay the flags by GLYPH_LAT pixels to meet the glyph bit.
  assign w_flags_p0 = '{vis: w_vis_p0, hs_n: w_hs_n_p0, vs_n: w_vs_n_p0};

  if (GLYPH_LAT == 0) begin : g_no_dly
    assign w_flags_p1 = w_flags_p0;
  end else begin : g_dly
    sync_flags_t r_dly_p1 [GLYPH_LAT];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < GLYPH_LAT; i++) begin
          r_dly_p1[i] <= FLAGS_IDLE;
        end
      end else if (w_p_tick) begin
        r_dly_p1[0] <= w_flags_p0;
        for (int i = 1; i < GLYPH_LAT; i++) begin
          r_dly_p1[i] <= r_dly_p1[i-1];
        end
      end
    end

    assign w_flags_p1 = r_dly_p1[GLYPH_LAT-1];
  end

  assign w_text_on_p1 = glyph_bit && w_flags_p1.vis && r_blink_vis;

  // Stage 1 -> stage 2: output register; blanking always yields black.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync_p2    <= 1'b1;
      r_vsync_p2    <= 1'b1;
      r_video_on_p2 <= 1'b0;
      r_text_on_p2  <= 1'b0;
      r_text_rgb_p2 <= BLACK;
    end else if (w_p_tick) begin
      r_hsync_p2    <= w_flags_p1.hs_n;
      r_vsync_p2    <= w_flags_p1.vs_n;
      r_video_on_p2 <= w_flags_p1.vis;
      r_text_on_p2  <= w_text_on_p1;
      r_text_rgb_p2 <= w_text_on_p1 ? r_active : BLACK;
    end
  end

  assign p_tick      = w_p_tick;
  assign pixel_x     = w_pixel_x;
  assign pixel_y     = w_pixel_y;
  assign frame_start = w_frame_start;
  assign hsync       = r_hsync_p2;
  assign vsync       = r_vsync_p2;
  assign video_on    = r_video_on_p2;
  assign text_on     = r_text_on_p2;
  assign text_rgb    = r_text_rgb_p2;

endmodule
